tv_writer: RTL and testbench

Synthesizable test-vector generator for the 1-bit full-adder verification flow. On a start request it sweeps all eight {a, b, ci} combinations, computes the golden sum and carry, and writes 5-bit vectors {a, b, ci, se, coe} into a vector memory through a valid/ready write port. The bench-side reader consumes the same 5-bit format. The block reports how many vectors it wrote and whether the sweep was truncated by memory depth.

---
 rtl/tv_writer.sv | 103 ++++++++++
 tb/tb_tv_writer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/tv_writer.sv
// Full-adder test-vector generator: sweeps {a,b,ci} and writes {a,b,ci,sum,carry}
// vectors into a memory through a valid/ready write port, stopping at PASSES*8 or DEPTH.
module tv_writer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int PASSES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [4:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              truncated,
  output logic [ADDR_W:0]   count
);

  localparam int PASS_W = $clog2(PASSES) + 1;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          p_q, p_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                trunc_q, trunc_d;

  logic [ADDR_W:0]     countInc;
  logic                hitTotal;
  logic                hitDepth;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      pass_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      pass_q  <= pass_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      trunc_q <= trunc_d;
    end
  end

  // The pattern is left on the last written value at termination so wr_data keeps showing it in DONE.
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    pass_d   = pass_q;
    addr_d   = addr_q;
    count_d  = count_q;
    trunc_d  = trunc_q;
    countInc = count_q + 1'b1;
    hitTotal = (p_q == 3'd7) && (pass_q == PASS_W'(PASSES - 1));
    hitDepth = (32'(countInc) == 32'(DEPTH));
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = WRITE;
          p_d     = '0;
          pass_d  = '0;
          addr_d  = '0;
          count_d = '0;
          trunc_d = 1'b0;
        end
      end
      WRITE: begin
        if (wr_ready) begin
          count_d = countInc;
          addr_d  = addr_q + 1'b1;
          if (hitTotal || hitDepth) begin
            state_d = DONE;
            trunc_d = !hitTotal;
          end else begin
            p_d = p_q + 1'b1;
            if (p_q == 3'd7) begin
              pass_d = pass_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_en     = (state_q == WRITE);
  assign busy      = (state_q == WRITE);
  assign done      = (state_q == DONE);
  assign truncated = trunc_q;
  assign count     = count_q;
  assign wr_addr   = addr_q;
  assign wr_data   = {p_q, ^p_q, (p_q[2] & p_q[1]) | (p_q[2] & p_q[0]) | (p_q[1] & p_q[0])};

endmodule

// File: tb/tb_tv_writer.sv
// Directed bench for tv_writer: default sweep, backpressure, two passes, depth truncation,
// mid-run reset and ignored start while busy.
module tb_tv_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic startA, readyA, startB, readyB, startC, readyC;

  logic       wrEnA, busyA, doneA, truncA;
  logic [3:0] addrA;
  logic [4:0] dataA;
  logic [4:0] countA;

  logic       wrEnB, busyB, doneB, truncB;
  logic [3:0] addrB;
  logic [4:0] dataB;
  logic [4:0] countB;

  logic       wrEnC, busyC, doneC, truncC;
  logic [2:0] addrC;
  logic [4:0] dataC;
  logic [3:0] countC;

  int checks   = 0;
  int failures = 0;
  logic [4:0] expVec [8];

  tv_writer uA (
    .clk(clk), .reset(reset), .start(startA), .wr_ready(readyA),
    .wr_en(wrEnA), .wr_addr(addrA), .wr_data(dataA), .busy(busyA),
    .done(doneA), .truncated(truncA), .count(countA)
  );

  tv_writer #(.DEPTH(16), .ADDR_W(4), .PASSES(2)) uB (
    .clk(clk), .reset(reset), .start(startB), .wr_ready(readyB),
    .wr_en(wrEnB), .wr_addr(addrB), .wr_data(dataB), .busy(busyB),
    .done(doneB), .truncated(truncB), .count(countB)
  );

  tv_writer #(.DEPTH(6), .ADDR_W(3), .PASSES(1)) uC (
    .clk(clk), .reset(reset), .start(startC), .wr_ready(readyC),
    .wr_en(wrEnC), .wr_addr(addrC), .wr_data(dataC), .busy(busyC),
    .done(doneC), .truncated(truncC), .count(countC)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  initial begin
    expVec[0] = 5'b00000; expVec[1] = 5'b00110; expVec[2] = 5'b01010; expVec[3] = 5'b01101;
    expVec[4] = 5'b10010; expVec[5] = 5'b10101; expVec[6] = 5'b11001; expVec[7] = 5'b11111;
    reset = 1'b1;
    startA = 1'b0; readyA = 1'b0; startB = 1'b0; readyB = 1'b0; startC = 1'b0; readyC = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_wr_en", 32'(wrEnA), 32'd0);
    checkOutput("rst_busy", 32'(busyA), 32'd0);
    checkOutput("rst_done", 32'(doneA), 32'd0);
    checkOutput("rst_trunc", 32'(truncA), 32'd0);
    checkOutput("rst_addr", 32'(addrA), 32'd0);
    checkOutput("rst_data", 32'(dataA), 32'd0);
    checkOutput("rst_count", 32'(countA), 32'd0);

    // Default sweep with the memory always ready.
    reset = 1'b0; startA = 1'b1; readyA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("a_wr_en", 32'(wrEnA), 32'd1);
      checkOutput("a_busy", 32'(busyA), 32'd1);
      checkOutput("a_addr", 32'(addrA), 32'(i));
      checkOutput("a_data", 32'(dataA), 32'(expVec[i]));
      checkOutput("a_count", 32'(countA), 32'(i));
      @(negedge clk);
    end
    checkOutput("a_done", 32'(doneA), 32'd1);
    checkOutput("a_busy_end", 32'(busyA), 32'd0);
    checkOutput("a_wr_en_end", 32'(wrEnA), 32'd0);
    checkOutput("a_count_end", 32'(countA), 32'd8);
    checkOutput("a_trunc", 32'(truncA), 32'd0);
    checkOutput("a_addr_end", 32'(addrA), 32'd8);
    checkOutput("a_data_end", 32'(dataA), 32'h1f);
    @(negedge clk);
    checkOutput("a_done_hold", 32'(doneA), 32'd1);

    // Same sweep with wr_ready low on alternate cycles.
    startA = 1'b1; readyA = 1'b0;
    @(negedge clk);
    startA = 1'b0;
    checkOutput("bp_count_clr", 32'(countA), 32'd0);
    checkOutput("bp_done_clr", 32'(doneA), 32'd0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("bp_addr", 32'(addrA), 32'(i));
      checkOutput("bp_data", 32'(dataA), 32'(expVec[i]));
      @(negedge clk);
      checkOutput("bp_addr_stall", 32'(addrA), 32'(i));
      checkOutput("bp_data_stall", 32'(dataA), 32'(expVec[i]));
      checkOutput("bp_wr_en_stall", 32'(wrEnA), 32'd1);
      readyA = 1'b1;
      @(negedge clk);
      readyA = 1'b0;
    end
    checkOutput("bp_done", 32'(doneA), 32'd1);
    checkOutput("bp_count", 32'(countA), 32'd8);

    // Two passes into a 16-deep memory.
    startB = 1'b1; readyB = 1'b1;
    @(negedge clk);
    startB = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checkOutput("p2_addr", 32'(addrB), 32'(i));
      checkOutput("p2_data", 32'(dataB), 32'(expVec[i % 8]));
      @(negedge clk);
    end
    checkOutput("p2_done", 32'(doneB), 32'd1);
    checkOutput("p2_count", 32'(countB), 32'd16);
    checkOutput("p2_trunc", 32'(truncB), 32'd0);
    checkOutput("p2_addr_end", 32'(addrB), 32'd0);

    // Six-entry memory truncates the sweep.
    startC = 1'b1; readyC = 1'b1;
    @(negedge clk);
    startC = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checkOutput("tr_addr", 32'(addrC), 32'(i));
      checkOutput("tr_data", 32'(dataC), 32'(expVec[i]));
      @(negedge clk);
    end
    checkOutput("tr_done", 32'(doneC), 32'd1);
    checkOutput("tr_busy", 32'(busyC), 32'd0);
    checkOutput("tr_count", 32'(countC), 32'd6);
    checkOutput("tr_trunc", 32'(truncC), 32'd1);
    checkOutput("tr_addr_end", 32'(addrC), 32'd6);
    checkOutput("tr_data_end", 32'(dataC), 32'h15);

    // Reset in the cycle where wr_addr is 3.
    startA = 1'b1; readyA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mr_addr_pre", 32'(addrA), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mr_wr_en", 32'(wrEnA), 32'd0);
    checkOutput("mr_busy", 32'(busyA), 32'd0);
    checkOutput("mr_done", 32'(doneA), 32'd0);
    checkOutput("mr_addr", 32'(addrA), 32'd0);
    checkOutput("mr_data", 32'(dataA), 32'd0);
    checkOutput("mr_count", 32'(countA), 32'd0);
    @(negedge clk);
    checkOutput("mr_idle_wr_en", 32'(wrEnA), 32'd0);

    // Restart, with a second start pulse at edge k+3 that must be ignored.
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("rs_addr", 32'(addrA), 32'(i));
      checkOutput("rs_data", 32'(dataA), 32'(expVec[i]));
      startA = (i == 2);
      @(negedge clk);
    end
    startA = 1'b0;
    checkOutput("rs_done", 32'(doneA), 32'd1);
    checkOutput("rs_count", 32'(countA), 32'd8);
    checkOutput("rs_trunc", 32'(truncA), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
